// File: rtl/mem_bus_ctrl_if.sv
// Request, response and memory-bus signals of mem_bus_ctrl bundled as one interface.
// slave is the controller's view; master is the view of the caches and memory around it.
interface mem_bus_ctrl_if #(
  parameter int XLEN = 32
);
  logic [1:0]           req_valid;
  logic [1:0][1:0]      req_cmd;
  logic [1:0][XLEN-1:0] req_addr;
  logic [1:0][63:0]     req_data;
  logic [1:0][1:0]      req_size;
  logic [1:0]           req_ready;
  logic [3:0]           req_tag;

  logic [1:0]           resp_valid;
  logic [3:0]           resp_tag;
  logic [63:0]          resp_data;
  logic                 tag_err;

  logic [1:0]           proc2mem_command;
  logic [XLEN-1:0]      proc2mem_addr;
  logic [63:0]          proc2mem_data;
  logic [1:0]           proc2mem_size;
  logic [3:0]           mem2proc_response;
  logic [63:0]          mem2proc_data;
  logic [3:0]           mem2proc_tag;

  modport slave (
    input  req_valid, req_cmd, req_addr, req_data, req_size,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output req_ready, req_tag, resp_valid, resp_tag, resp_data, tag_err,
    output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
  );

  modport master (
    output req_valid, req_cmd, req_addr, req_data, req_size,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  req_ready, req_tag, resp_valid, resp_tag, resp_data, tag_err,
    input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Two-port (I-cache / D-cache) round-robin initiator for the tagged memory bus with load-tag routing.
// Optional saturating statistics counters are enabled by defining MEM_BUS_CTRL_STATS_EN.
module mem_bus_ctrl #(
  parameter int NUM_TAGS        = 15,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic          clock,
  input  logic          reset,
  mem_bus_ctrl_if.slave bus
`ifdef MEM_BUS_CTRL_STATS_EN
  ,
  output logic [31:0]   stat_accepts,
  output logic [31:0]   stat_rejects,
  output logic [31:0]   stat_returns
`endif
);
  localparam int               TAG_W     = 4;
  localparam int               TAG_SLOTS = 1 << TAG_W;
  localparam int               CNT_W     = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [1:0]       BUS_NONE  = 2'd0;
  localparam logic [1:0]       BUS_LOAD  = 2'd1;
  localparam logic [1:0]       BUS_STORE = 2'd2;

  // Owner table indexed directly by tag; slot 0 and slots above NUM_TAGS are never written.
  logic [TAG_SLOTS-1:0]  own_valid_reg;
  logic [TAG_SLOTS-1:0]  own_port_reg;
  logic [1:0][CNT_W-1:0] cnt_reg;
  logic                  ptr_reg;
  logic [1:0]            resp_valid_reg;
  logic [TAG_W-1:0]      resp_tag_reg;
  logic [63:0]           resp_data_reg;
  logic                  tag_err_reg;

  logic [1:0][1:0]       cmd_eff;
  logic [1:0]            elig;
  logic                  grant_valid;
  logic                  grant_port;
  logic                  accept;
  logic                  accept_load;
  logic                  ret_hit;
  logic                  ret_miss;
  logic                  ret_port;
  logic [1:0]            cnt_inc;
  logic [1:0]            cnt_dec;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      if (gi == 0) begin : g_icache
        // The I-cache never stores; a stray store is squashed to an idle command.
        assign cmd_eff[gi] = (bus.req_cmd[gi] == BUS_STORE) ? BUS_NONE : bus.req_cmd[gi];
      end else begin : g_dcache
        assign cmd_eff[gi] = bus.req_cmd[gi];
      end
      assign elig[gi] = bus.req_valid[gi] &&
                        ((cmd_eff[gi] == BUS_STORE) ||
                         ((cmd_eff[gi] == BUS_LOAD) && (cnt_reg[gi] < CNT_MAX)));
      assign cnt_inc[gi] = accept_load && (grant_port == gi[0]);
      assign cnt_dec[gi] = ret_hit && (ret_port == gi[0]);
    end
  endgenerate

  always_comb begin
    grant_valid = 1'b0;
    grant_port  = ptr_reg;
    if (!reset) begin
      if (elig[ptr_reg]) begin
        grant_valid = 1'b1;
        grant_port  = ptr_reg;
      end else if (elig[~ptr_reg]) begin
        grant_valid = 1'b1;
        grant_port  = ~ptr_reg;
      end
    end
  end

  assign accept      = grant_valid && (bus.mem2proc_response != '0);
  assign accept_load = accept && (cmd_eff[grant_port] == BUS_LOAD);

  assign ret_hit  = own_valid_reg[bus.mem2proc_tag];
  assign ret_miss = (bus.mem2proc_tag != '0) && !ret_hit;
  assign ret_port = own_port_reg[bus.mem2proc_tag];

  always_comb begin
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = bus.req_addr[grant_port];
    bus.proc2mem_data    = bus.req_data[grant_port];
    bus.proc2mem_size    = bus.req_size[grant_port];
    bus.req_ready        = 2'b00;
    bus.req_tag          = '0;
    if (grant_valid) begin
      bus.proc2mem_command = cmd_eff[grant_port];
    end
    if (accept) begin
      bus.req_ready[grant_port] = 1'b1;
      bus.req_tag               = bus.mem2proc_response;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      own_valid_reg  <= '0;
      own_port_reg   <= '0;
      cnt_reg        <= '0;
      ptr_reg        <= 1'b1;
      resp_valid_reg <= 2'b00;
      resp_tag_reg   <= '0;
      resp_data_reg  <= '0;
      tag_err_reg    <= 1'b0;
    end else begin
      resp_valid_reg <= 2'b00;
      if (ret_hit) begin
        resp_valid_reg[ret_port] <= 1'b1;
        resp_tag_reg             <= bus.mem2proc_tag;
        resp_data_reg            <= bus.mem2proc_data;
      end
      if (ret_miss) begin
        tag_err_reg <= 1'b1;
      end

      // Return clears first so a same-cycle re-allocation of that tag wins.
      for (int i = 1; i < TAG_SLOTS; i++) begin
        if (i <= NUM_TAGS) begin
          if (ret_hit && (bus.mem2proc_tag == TAG_W'(i))) begin
            own_valid_reg[i] <= 1'b0;
          end
          if (accept_load && (bus.mem2proc_response == TAG_W'(i))) begin
            own_valid_reg[i] <= 1'b1;
            own_port_reg[i]  <= grant_port;
          end
        end
      end

      for (int p = 0; p < 2; p++) begin
        if (cnt_inc[p] && !cnt_dec[p]) begin
          cnt_reg[p] <= cnt_reg[p] + CNT_ONE;
        end else if (cnt_dec[p] && !cnt_inc[p]) begin
          cnt_reg[p] <= cnt_reg[p] - CNT_ONE;
        end
      end

      if (accept) begin
        ptr_reg <= ~grant_port;
      end
    end
  end

  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_tag   = resp_tag_reg;
  assign bus.resp_data  = resp_data_reg;
  assign bus.tag_err    = tag_err_reg;

`ifdef MEM_BUS_CTRL_STATS_EN
  logic [31:0] stat_accepts_reg;
  logic [31:0] stat_rejects_reg;
  logic [31:0] stat_returns_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_accepts_reg <= '0;
      stat_rejects_reg <= '0;
      stat_returns_reg <= '0;
    end else begin
      if (accept && (stat_accepts_reg != '1)) begin
        stat_accepts_reg <= stat_accepts_reg + 32'd1;
      end
      if (grant_valid && !accept && (stat_rejects_reg != '1)) begin
        stat_rejects_reg <= stat_rejects_reg + 32'd1;
      end
      if (ret_hit && (stat_returns_reg != '1)) begin
        stat_returns_reg <= stat_returns_reg + 32'd1;
      end
    end
  end

  assign stat_accepts = stat_accepts_reg;
  assign stat_rejects = stat_rejects_reg;
  assign stat_returns = stat_returns_reg;
`endif
endmodule
